// File: rtl/full_adder_bist_if.sv
// Operand/result bus between the BIST exerciser and the adder under test.
// master drives operands, slave returns sum/carry.
interface full_adder_bist_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output a, b, cin,
    input  sum, cout
  );

  modport slave (
    input  a, b, cin,
    output sum, cout
  );
endinterface

// File: rtl/full_adder_bist.sv
// Exhaustive on-chip exerciser for a WIDTH-bit adder: sweeps {a,b,cin},
// compares {cout,sum} against a golden sum, reports errors and first failure.
module full_adder_bist #(
  parameter int WIDTH  = 1,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  full_adder_bist_if.master    ad,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*WIDTH+1:0]   err_count,
  output logic [2*WIDTH:0]     fail_vec
);

  localparam int VW = 2*WIDTH+1;
  localparam int EW = 2*WIDTH+2;
  localparam int GW = WIDTH+1;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE-1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  state_t        state, state_n;
  logic [VW-1:0] vec;
  logic [CW-1:0] cnt;
  logic [GW-1:0] golden;
  logic [GW-1:0] got;
  logic          mismatch;
  logic          last;
  logic          launch;

  assign ad.a   = vec[VW-1:WIDTH+1];
  assign ad.b   = vec[WIDTH:1];
  assign ad.cin = vec[0];

  // golden kept at WIDTH+1 bits so the carry is compared too
  assign golden = {1'b0, vec[VW-1:WIDTH+1]}
                + {1'b0, vec[WIDTH:1]}
                + GW'(vec[0]);
  assign got      = {ad.cout, ad.sum};
  assign mismatch = (got != golden);
  assign last     = &vec;
  assign pass     = done && (err_count == '0);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    launch  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          launch  = 1'b1;
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        busy = 1'b1;
        if (cnt == '0) state_n = S_CHECK;
      end
      S_CHECK: begin
        busy    = 1'b1;
        state_n = last ? S_DONE : S_WAIT;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          launch  = 1'b1;
          state_n = S_WAIT;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vec       <= '0;
      cnt       <= '0;
      err_count <= '0;
      fail_vec  <= '0;
    end else if (launch) begin
      vec       <= '0;
      cnt       <= CNT_INIT;
      err_count <= '0;
      fail_vec  <= '0;
    end else if (state == S_WAIT) begin
      if (cnt != '0) cnt <= cnt - CW'(1);
    end else if (state == S_CHECK) begin
      if (mismatch) begin
        err_count <= err_count + EW'(1);
        if (err_count == '0) fail_vec <= vec;
      end
      if (!last) begin
        vec <= vec + VW'(1);
        cnt <= CNT_INIT;
      end
    end
  end

endmodule

// File: tb/tb_full_adder_bist.sv
// Bench for full_adder_bist: behavioural adders with injectable faults,
// vector scoreboard, reset/abort/restart and a 2-bit wide instance.
module tb_full_adder_bist;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start1 = 1'b0;
  logic start2 = 1'b0;
  int   mode1 = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  full_adder_bist_if #(.WIDTH(1)) i1 ();
  full_adder_bist_if #(.WIDTH(2)) i2 ();

  logic       busy1, done1, pass1;
  logic [3:0] err1;
  logic [2:0] fv1;
  logic       busy2, done2, pass2;
  logic [5:0] err2;
  logic [4:0] fv2;

  full_adder_bist #(.WIDTH(1), .SETTLE(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .ad(i1),
    .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_vec(fv1)
  );

  full_adder_bist #(.WIDTH(2), .SETTLE(2)) u2 (
    .clk(clk), .rst(rst), .start(start2), .ad(i2),
    .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .fail_vec(fv2)
  );

  // mode 0 ideal, 1 sum stuck at 0, 2 cout inverted
  logic [1:0] t1;
  always_comb begin
    t1 = {1'b0, i1.a} + {1'b0, i1.b} + {1'b0, i1.cin};
    i1.sum  = (mode1 == 1) ? 1'b0 : t1[0];
    i1.cout = (mode1 == 2) ? ~t1[1] : t1[1];
  end

  assign {i2.cout, i2.sum} = {1'b0, i2.a} + {1'b0, i2.b} + {2'b0, i2.cin};

  // unified view of the selected instance
  int         sel = 0;
  logic [4:0] ov;
  logic       ob, od, op;
  logic [5:0] oe;
  logic [4:0] of;
  always_comb begin
    if (sel == 0) begin
      ov = {2'b0, i1.a, i1.b, i1.cin};
      ob = busy1; od = done1; op = pass1;
      oe = {2'b0, err1}; of = {2'b0, fv1};
    end else begin
      ov = {i2.a, i2.b, i2.cin};
      ob = busy2; od = done2; op = pass2;
      oe = err2; of = fv2;
    end
  end

  int q[$];

  task automatic run(input int s, input int m, input bit hold,
                     input int xerr, input int xfail, input bit xpass);
    int nv, st, ev;
    nv = (s == 0) ? 8 : 32;
    st = (s == 0) ? 2 : 3;
    sel = s;
    mode1 = m;
    @(negedge clk);
    if (s == 0) start1 = 1'b1; else start2 = 1'b1;
    for (int v = 0; v < nv; v++) q.push_back(v);
    ev = 0;
    @(posedge clk); #1;
    if (!hold) begin start1 = 1'b0; start2 = 1'b0; end
    tests++;
    if (oe !== 6'd0 || of !== 5'd0) begin
      fails++;
      $display("FAIL launch_clear got err=%0d fv=%0d want 0/0", oe, of);
    end
    for (int c = 0; c < nv*st; c++) begin
      if (c % st == 0) ev = q.pop_front();
      tests++;
      if (ov !== 5'(ev) || ob !== 1'b1 || od !== 1'b0) begin
        fails++;
        $display("FAIL vec c=%0d got v=%0d b=%b d=%b want v=%0d b=1 d=0",
                 c, ov, ob, od, ev);
      end
      @(posedge clk); #1;
    end
    start1 = 1'b0; start2 = 1'b0;
    tests++;
    if (od !== 1'b1 || ob !== 1'b0 || op !== xpass ||
        oe !== 6'(xerr) || of !== 5'(xfail) || q.size() != 0) begin
      fails++;
      $display("FAIL result got d=%b b=%b p=%b e=%0d f=%0d want 1 0 %b %0d %0d",
               od, ob, op, oe, of, xpass, xerr, xfail);
    end
    @(posedge clk); #1;
    tests++;
    if (od !== 1'b1 || ov !== 5'(nv-1) || oe !== 6'(xerr)) begin
      fails++;
      $display("FAIL done_hold got d=%b v=%0d e=%0d want 1 %0d %0d",
               od, ov, oe, nv-1, xerr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({busy1, done1, pass1, err1, fv1, i1.a, i1.b, i1.cin} !== '0 ||
        {busy2, done2, pass2, err2, fv2, i2.a, i2.b, i2.cin} !== '0) begin
      fails++;
      $display("FAIL reset got b=%b d=%b p=%b e=%0d f=%0d want all 0",
               busy1, done1, pass1, err1, fv1);
    end
    @(negedge clk); rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (busy1 !== 1'b0 || done1 !== 1'b0) begin
      fails++;
      $display("FAIL idle_stay got b=%b d=%b want 0 0", busy1, done1);
    end
  endtask

  task automatic test_abort();
    bit seen;
    sel = 0;
    mode1 = 0;
    seen = 0;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if ({i1.a, i1.b, i1.cin} == 3'b101) seen = 1;
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL abort_reach got vec=%0d want 5", {i1.a, i1.b, i1.cin});
    end
    rst = 1'b1;
    @(posedge clk); #1;
    tests++;
    if ({busy1, done1, pass1, err1, fv1, i1.a, i1.b, i1.cin} !== '0) begin
      fails++;
      $display("FAIL abort got b=%b d=%b v=%0d e=%0d want all 0",
               busy1, done1, {i1.a, i1.b, i1.cin}, err1);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (busy1 !== 1'b0) begin
      fails++;
      $display("FAIL abort_idle got b=%b want 0", busy1);
    end
  endtask

  initial begin
    test_reset();
    run(0, 0, 1'b0, 0, 0, 1'b1);
    run(0, 1, 1'b0, 4, 1, 1'b0);
    run(0, 2, 1'b0, 8, 0, 1'b0);
    run(0, 0, 1'b0, 0, 0, 1'b1);
    run(0, 0, 1'b1, 0, 0, 1'b1);
    test_abort();
    run(0, 0, 1'b0, 0, 0, 1'b1);
    run(1, 0, 1'b0, 0, 0, 1'b1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
